// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions for the rotation and vectoring blocks.
// Angles are 32-bit binary angles: 2^32 = 360 degrees.
// The ATAN table holds atan(2^-i) in binary-angle units.
package cordic_pkg;

    localparam int CORDIC_ITER = 16;
    localparam int ANGLE_W     = 32;
    localparam int DATA_W      = 16;
    // Two guard bits cover the sqrt(2) * 1.647 growth of the vector.
    localparam int XY_W        = DATA_W + 2;
    localparam int CNT_W       = $clog2(CORDIC_ITER);

    localparam logic [ANGLE_W-1:0] ANG_90  = 32'h4000_0000;
    localparam logic [ANGLE_W-1:0] ANG_M90 = 32'hC000_0000;

    localparam logic [ANGLE_W-1:0] ATAN [0:CORDIC_ITER-1] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } vec_state_t;

    function automatic logic [ANGLE_W-1:0] atan_lut(input logic [CNT_W-1:0] idx);
        return ATAN[idx];
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation (purely combinational).
// Drives y toward zero: the rotation direction follows the sign of y,
// and z accumulates the angle that has been rotated away.
// Ports:
//   x, y, z, i              current vector, angle accumulator, iteration index
//   x_next, y_next, z_next  values after this micro-rotation
module cordic_vec_stage
    import cordic_pkg::*;
(
    input  logic signed [XY_W-1:0]    x,
    input  logic signed [XY_W-1:0]    y,
    input  logic        [ANGLE_W-1:0] z,
    input  logic        [CNT_W-1:0]   i,
    output logic signed [XY_W-1:0]    x_next,
    output logic signed [XY_W-1:0]    y_next,
    output logic        [ANGLE_W-1:0] z_next
);

    logic signed [XY_W-1:0] x_sh;
    logic signed [XY_W-1:0] y_sh;

    always_comb begin
        x_sh = x >>> i;
        y_sh = y >>> i;
        if (!y[XY_W-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_lut(i);
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_lut(i);
        end
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (xin, yin) -> gain-scaled magnitude and
// atan2(yin, xin) as a 32-bit binary angle. One micro-rotation per clock.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          request, sampled only while idle
//   xin, yin       signed 16-bit input vector
//   busy           high from the accept edge until done is raised
//   done           one-cycle pulse, mag/angle valid (and held afterwards)
//   mag            unsigned magnitude, ~1.64676 * sqrt(x^2 + y^2)
//   angle          signed binary angle, 0x40000000 = +90 degrees
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = CORDIC_ITER
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] xin,
    input  logic signed [DATA_W-1:0] yin,
    output logic                     busy,
    output logic                     done,
    output logic        [DATA_W:0]   mag,
    output logic        [ANGLE_W-1:0] angle
);

    vec_state_t state;
    vec_state_t state_next;

    logic signed [XY_W-1:0]    x;
    logic signed [XY_W-1:0]    y;
    logic        [ANGLE_W-1:0] z;
    logic        [CNT_W-1:0]   i;

    logic signed [XY_W-1:0]    x_next;
    logic signed [XY_W-1:0]    y_next;
    logic        [ANGLE_W-1:0] z_next;

    logic signed [XY_W-1:0]    xe;
    logic signed [XY_W-1:0]    ye;
    logic signed [XY_W-1:0]    x_pre;
    logic signed [XY_W-1:0]    y_pre;
    logic        [ANGLE_W-1:0] z_pre;

    logic last_iter;

    assign xe        = {{(XY_W-DATA_W){xin[DATA_W-1]}}, xin};
    assign ye        = {{(XY_W-DATA_W){yin[DATA_W-1]}}, yin};
    assign last_iter = (i == CNT_W'(ITER - 1));

    // Quadrant pre-rotation: fold the left half-plane into the right one by
    // +/-90 degrees so the micro-rotations only need to cover +/-99.9 degrees.
    always_comb begin
        if (!xin[DATA_W-1]) begin
            x_pre = xe;
            y_pre = ye;
            z_pre = '0;
        end else if (!yin[DATA_W-1]) begin
            x_pre = ye;
            y_pre = -xe;
            z_pre = ANG_90;
        end else begin
            x_pre = -ye;
            y_pre = xe;
            z_pre = ANG_M90;
        end
    end

    cordic_vec_stage u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .i      (i),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    // Control state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_ITER;
            ST_ITER: if (last_iter) state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Datapath: accept / iterate / publish
    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            i     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mag   <= '0;
            angle <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x    <= x_pre;
                        y    <= y_pre;
                        z    <= z_pre;
                        i    <= '0;
                        busy <= 1'b1;
                    end
                end
                ST_ITER: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    i <= i + 1'b1;
                end
                ST_DONE: begin
                    // x is non-negative after pre-rotation, so the sign bit is dropped.
                    mag   <= x[DATA_W:0];
                    angle <= z;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC: the inverse of the rotation-mode `cordic` block. It takes a Cartesian vector (x, y) and returns its CORDIC-gain-scaled magnitude and its angle, atan2(y, x), in the same 32-bit binary angle format the rotation block consumes (2^32 = 360°). It sits beside the rotation block so downstream logic can convert polar to Cartesian and back with one angle convention. One micro-rotation runs per clock, with a start/done handshake.

## Interface
- `ITER`, 16: number of micro-rotations. Fixed at 16 for this release.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `xin` in 16: signed two's-complement x.
- `yin` in 16: signed two's-complement y.
- `busy` out 1: high from the accept edge until done is set.
- `done` out 1: one-cycle pulse; `mag` and `angle` are valid.
- `mag` out 17: unsigned magnitude ≈ 1.64676·sqrt(x²+y²). The gain is not compensated.
- `angle` out 32: signed binary angle; 0x40000000 = +90°, 0x80000000 = ±180°.

## Operation
- States:
  - IDLE → ITER on `start`.
  - ITER → DONE after iteration ITER-1.
  - DONE → IDLE unconditionally.
- Internal registers:
  - x, y: 18-bit signed. Worst case is 32768·√2·1.647 ≈ 76.3k, which fits.
  - z: 32-bit.
  - i: 4-bit iteration counter.
- Accept edge (IDLE and `start`): sign-extend the inputs and apply quadrant pre-rotation.
  - xin ≥ 0: x=xin, y=yin, z=0.
  - xin < 0 and yin ≥ 0: x=yin, y=−xin, z=0x40000000.
  - xin < 0 and yin < 0: x=−yin, y=xin, z=0xC0000000.
  - Set i=0 and `busy`=1.
- Each ITER edge:
  - y ≥ 0: x+=y>>>i, y−=x>>>i, z+=ATAN[i].
  - y < 0: x−=y>>>i, y+=x>>>i, z−=ATAN[i].
  - All right-hand sides use the old register values. Shifts are arithmetic. z wraps mod 2^32.
  - i increments each iteration.
- DONE entry edge: `mag`=x[16:0] (x ≥ 0 is guaranteed), `angle`=z, `done`=1, `busy`=0.
- Following edge: `done`=0. `mag` and `angle` hold until the next DONE.
- `start` during ITER or DONE is ignored and not queued. `xin`/`yin` are don't-care after the accept edge.
- (0,0) input: mag=0, angle is whatever accumulates (unspecified, deterministic). No error flag.
- xin=−32768 is legal; pre-rotated y=+32768 fits in 18 bits.

## Timing
- Reset values: `busy`=0, `done`=0, `mag`=0, `angle`=0, state IDLE, x/y/z/i=0.
- Reset mid-operation aborts immediately: no `done`, outputs return to 0, `start` is accepted on the first edge after reset deasserts.
- Latency: accept at edge E0. Iterations run at E1..E16. `done` is high during the cycle following E17.
- Throughput: one result per 18 cycles. `start` held high continuously restarts on the first IDLE cycle after DONE.
- Accuracy: |angle error| ≤ 0x10000 (≈0.0055°). |mag error| ≤ 2 LSB versus 1.64676·r.

## Structure
- Package `cordic_pkg` holds:
  - `CORDIC_ITER`=16.
  - `ANGLE_W`=32.
  - Angle constants `ANG_90`=0x40000000 and `ANG_M90`=0xC0000000.
  - `ATAN` table in binary-angle units, shared with `cordic`: 0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4, 0x028B0D43, 0x0145D7E1, 0x00A2F61E, 0x00517C55, 0x0028BE53, 0x00145F2F, 0x000A2F98, 0x000517CC, 0x00028BE6, 0x000145F3, 0x0000A2FA, 0x0000517D.
- One natural sub-module, `cordic_vec_stage`: the combinational single micro-rotation (x, y, z, i → x′, y′, z′), reusable for a future unrolled version.

## Test plan
- (1200, 0) → done at E17, mag≈1976, angle≈0x00000000.
- (600, 1039) → mag≈1976, angle≈0x2AAAAAAA (60°).
- Negative half-plane:
  - (−1200, 0) → angle≈0x80000000, mag≈1976.
  - (0, −1200) → angle≈0xC0000000.
  - (−600, 1039) → angle≈0x55555555 (120°).
- Extremes: (−32768, −32768) → mag≈76314, angle≈0xA0000000 (−135°), no overflow. (0, 0) → mag=0.
- `start` pulsed at E5 during ITER → ignored; exactly one done. `start` held high → done every 18 cycles with fresh inputs.
- `reset` asserted at E8 → `busy`/`done`/`mag`/`angle`=0 next cycle, no done pulse; a new request afterwards completes normally.
